fcounter_trim_sar: RTL and testbench



---
 rtl/fcounter_trim_pkg.sv | 34 +++
 rtl/fcounter_trim_seq.sv | 136 +++++++++++++
 rtl/fcounter_trim_sar.sv | 213 +++++++++++++++++++++
 tb/tb_fcounter_trim_sar.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fcounter_trim_pkg.sv
// Shared types and counter sizing for the fcounter trim SAR controller.
// Imported by fcounter_trim_seq and fcounter_trim_sar.
package fcounter_trim_pkg;

    typedef enum logic [3:0] {
        IDLE,
        SETTLE,
        ARM,
        WAIT_START,
        WINDOW,
        WAIT_EOM,
        ACK,
        DECIDE,
        DONE
    } state_t;

    localparam int DEF_SETTLE_CYCLES  = 16;
    localparam int DEF_WINDOW_CYCLES  = 320;
    localparam int DEF_TIMEOUT_CYCLES = 1023;

    localparam int SETTLE_CNT_W  = $clog2(DEF_SETTLE_CYCLES);
    localparam int WINDOW_CNT_W  = $clog2(DEF_WINDOW_CYCLES);
    localparam int TIMEOUT_CNT_W = $clog2(DEF_TIMEOUT_CYCLES);

    // Bits needed for a counter that runs 0..n-1.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max_w(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/fcounter_trim_seq.sv
// One fcounter measurement: ARM -> WAIT_START -> WINDOW -> WAIT_EOM -> ACK,
// with a shared timeout on both wait states.
module fcounter_trim_seq
    import fcounter_trim_pkg::*;
#(
    parameter int N              = 8,
    parameter int WINDOW_CYCLES  = DEF_WINDOW_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         meas_req,
    input  logic         fcounter_eom,
    input  logic [N-1:0] fcounter_adata,
    output logic         fcounter_som,
    output logic         fcounter_ce,
    output logic         meas_done,
    output logic         meas_timeout,
    output logic [N-1:0] meas_data
);

    localparam int WIN_W = max_w(cnt_w(WINDOW_CYCLES), WINDOW_CNT_W);
    localparam int TMO_W = max_w(cnt_w(TIMEOUT_CYCLES), TIMEOUT_CNT_W);

    state_t             state_q, state_d;
    logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
    logic [TMO_W-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic               som_q, som_d;
    logic               ce_q, ce_d;
    logic               done_q, done_d;
    logic               tmo_q, tmo_d;
    logic               eom_prev_q, eom_prev_d;
    logic [N-1:0]       data_q, data_d;
    logic               tmo_hit;

    assign tmo_hit = (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d    = state_q;
        win_cnt_d  = win_cnt_q;
        tmo_cnt_d  = tmo_cnt_q;
        som_d      = som_q;
        ce_d       = 1'b0;
        done_d     = 1'b0;
        tmo_d      = 1'b0;
        data_d     = data_q;
        eom_prev_d = fcounter_eom;
        case (state_q)
            IDLE: begin
                if (meas_req) begin
                    state_d = ARM;
                end
            end
            ARM: begin
                som_d     = 1'b1;
                ce_d      = 1'b1;
                tmo_cnt_d = '0;
                state_d   = WAIT_START;
            end
            WAIT_START: begin
                // eom is only trusted once fcounter has had a cycle to react to the ce.
                if (!ce_q && !fcounter_eom) begin
                    som_d     = 1'b0;
                    win_cnt_d = '0;
                    state_d   = WINDOW;
                end else if (tmo_hit) begin
                    som_d   = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            WINDOW: begin
                if (win_cnt_q == WIN_W'(WINDOW_CYCLES - 1)) begin
                    ce_d      = 1'b1;
                    tmo_cnt_d = '0;
                    state_d   = WAIT_EOM;
                end else begin
                    win_cnt_d = win_cnt_q + 1'b1;
                end
            end
            WAIT_EOM: begin
                if (fcounter_eom && !eom_prev_q) begin
                    data_d  = fcounter_adata;
                    state_d = ACK;
                end else if (tmo_hit) begin
                    som_d   = 1'b0;
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 1'b1;
                end
            end
            ACK: begin
                ce_d    = 1'b1;
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            win_cnt_q  <= '0;
            tmo_cnt_q  <= '0;
            som_q      <= 1'b0;
            ce_q       <= 1'b0;
            done_q     <= 1'b0;
            tmo_q      <= 1'b0;
            eom_prev_q <= 1'b0;
            data_q     <= '0;
        end else begin
            state_q    <= state_d;
            win_cnt_q  <= win_cnt_d;
            tmo_cnt_q  <= tmo_cnt_d;
            som_q      <= som_d;
            ce_q       <= ce_d;
            done_q     <= done_d;
            tmo_q      <= tmo_d;
            eom_prev_q <= eom_prev_d;
            data_q     <= data_d;
        end
    end

    assign fcounter_som = som_q;
    assign fcounter_ce  = ce_q;
    assign meas_done    = done_q;
    assign meas_timeout = tmo_q;
    assign meas_data    = data_q;

endmodule

// File: rtl/fcounter_trim_sar.sv
// SAR trim search over fcounter measurements, MSB first. Optional macro
// FCOUNTER_TRIM_FINAL_CHECK_EN adds a final verify measurement and a locked output.
module fcounter_trim_sar
    import fcounter_trim_pkg::*;
#(
    parameter int N              = 8,
    parameter int TRIM_W         = 6,
    parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
    parameter int WINDOW_CYCLES  = DEF_WINDOW_CYCLES,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
`ifdef FCOUNTER_TRIM_FINAL_CHECK_EN
    ,
    parameter int TOL            = 2
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [N-1:0]      target,
    input  logic              fcounter_rdy,
    input  logic              fcounter_eom,
    input  logic [N-1:0]      fcounter_adata,
    output logic              fcounter_som,
    output logic              fcounter_ce,
    output logic [TRIM_W-1:0] trim,
    output logic [N-1:0]      result,
    output logic              busy,
    output logic              done,
    output logic              error
`ifdef FCOUNTER_TRIM_FINAL_CHECK_EN
    ,
    output logic              locked
`endif
);

    localparam int SETTLE_W = max_w(cnt_w(SETTLE_CYCLES), SETTLE_CNT_W);
    localparam int BIT_W    = cnt_w(TRIM_W);
    localparam logic [TRIM_W-1:0] TRIM_INIT = TRIM_W'(1) << (TRIM_W - 1);
    localparam logic [BIT_W-1:0]  BIT_MSB   = BIT_W'(TRIM_W - 1);

    // Top-level states: ARM here means "measurement outstanding in the sequencer".
    state_t              state_q, state_d;
    logic [SETTLE_W-1:0] settle_cnt_q, settle_cnt_d;
    logic [BIT_W-1:0]    bit_q, bit_d;
    logic [TRIM_W-1:0]   trim_q, trim_d;
    logic [N-1:0]        target_q, target_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                error_q, error_d;
    logic                meas_req;
    logic                meas_done;
    logic                meas_timeout;
    logic [N-1:0]        meas_data;
    logic [TRIM_W-1:0]   cur_mask;
    logic [TRIM_W-1:0]   next_mask;
    logic                keep_bit;
`ifdef FCOUNTER_TRIM_FINAL_CHECK_EN
    logic                final_q, final_d;
    logic                locked_q, locked_d;
    logic                within_tol;

    assign within_tol = (meas_data <= target_q) && ((target_q - meas_data) <= N'(TOL));
`endif

    genvar gi;
    for (gi = 0; gi < TRIM_W; gi++) begin : g_mask
        assign cur_mask[gi] = (bit_q == BIT_W'(gi));
    end
    assign next_mask = cur_mask >> 1;
    assign keep_bit  = (meas_data <= target_q);

    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        bit_d        = bit_q;
        trim_d       = trim_q;
        target_d     = target_q;
        busy_d       = busy_q;
        done_d       = 1'b0;
        error_d      = error_q;
        meas_req     = 1'b0;
`ifdef FCOUNTER_TRIM_FINAL_CHECK_EN
        final_d      = final_q;
        locked_d     = locked_q;
`endif
        case (state_q)
            IDLE: begin
                if (start && fcounter_rdy) begin
                    target_d     = target;
                    trim_d       = TRIM_INIT;
                    bit_d        = BIT_MSB;
                    error_d      = 1'b0;
                    busy_d       = 1'b1;
                    settle_cnt_d = '0;
                    state_d      = SETTLE;
`ifdef FCOUNTER_TRIM_FINAL_CHECK_EN
                    final_d      = 1'b0;
                    locked_d     = 1'b0;
`endif
                end
            end
            SETTLE: begin
                if (settle_cnt_q == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                    meas_req = 1'b1;
                    state_d  = ARM;
                end else begin
                    settle_cnt_d = settle_cnt_q + 1'b1;
                end
            end
            ARM: begin
                if (meas_timeout) begin
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else if (meas_done) begin
                    state_d = DECIDE;
                end
            end
            DECIDE: begin
`ifdef FCOUNTER_TRIM_FINAL_CHECK_EN
                if (final_q) begin
                    state_d = DONE;
                end else
`endif
                begin
                    // Resolve the current bit and trial-set the next one in a single update.
                    trim_d = (keep_bit ? trim_q : (trim_q & ~cur_mask)) | next_mask;
                    if (bit_q == '0) begin
`ifdef FCOUNTER_TRIM_FINAL_CHECK_EN
                        final_d      = 1'b1;
                        settle_cnt_d = '0;
                        state_d      = SETTLE;
`else
                        state_d      = DONE;
`endif
                    end else begin
                        bit_d        = bit_q - 1'b1;
                        settle_cnt_d = '0;
                        state_d      = SETTLE;
                    end
                end
            end
            DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
`ifdef FCOUNTER_TRIM_FINAL_CHECK_EN
                locked_d = within_tol;
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            settle_cnt_q <= '0;
            bit_q        <= BIT_MSB;
            trim_q       <= TRIM_INIT;
            target_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
`ifdef FCOUNTER_TRIM_FINAL_CHECK_EN
            final_q      <= 1'b0;
            locked_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            bit_q        <= bit_d;
            trim_q       <= trim_d;
            target_q     <= target_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
`ifdef FCOUNTER_TRIM_FINAL_CHECK_EN
            final_q      <= final_d;
            locked_q     <= locked_d;
`endif
        end
    end

    fcounter_trim_seq #(
        .N              (N),
        .WINDOW_CYCLES  (WINDOW_CYCLES),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_seq (
        .clk            (clk),
        .rst            (rst),
        .meas_req       (meas_req),
        .fcounter_eom   (fcounter_eom),
        .fcounter_adata (fcounter_adata),
        .fcounter_som   (fcounter_som),
        .fcounter_ce    (fcounter_ce),
        .meas_done      (meas_done),
        .meas_timeout   (meas_timeout),
        .meas_data      (meas_data)
    );

    assign trim   = trim_q;
    assign result = meas_data;
    assign busy   = busy_q;
    assign done   = done_q;
    assign error  = error_q;
`ifdef FCOUNTER_TRIM_FINAL_CHECK_EN
    assign locked = locked_q;
`endif

endmodule

// File: tb/tb_fcounter_trim_sar.sv
// Bench for fcounter_trim_sar: behavioural fcounter + oscillator (count = mult*trim)
// and a scoreboard of expected final trim/result per accepted search.
module tb_fcounter_trim_sar;

    localparam int N      = 8;
    localparam int TRIM_W = 6;
`ifdef FCOUNTER_TRIM_FINAL_CHECK_EN
    localparam int TOL    = 2;
`endif

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [N-1:0]      target = '0;
    logic              fcounter_rdy;
    logic              fcounter_eom;
    logic [N-1:0]      fcounter_adata;
    logic              fcounter_som;
    logic              fcounter_ce;
    logic [TRIM_W-1:0] trim;
    logic [N-1:0]      result;
    logic              busy;
    logic              done;
    logic              error;
`ifdef FCOUNTER_TRIM_FINAL_CHECK_EN
    logic              locked;
`endif

    int errors = 0;
    int checks = 0;

    int   mult      = 2;
    bit   hang      = 1'b0;
    bit   rdy_ovr   = 1'b0;
    bit   model_rst = 1'b0;
    logic m_run     = 1'b0;
    logic m_eom     = 1'b0;
    logic [N-1:0] m_adata = '0;

    int   done_cnt = 0;
    int   ce_cnt   = 0;
    int   arm_cnt  = 0;
    int   ce_viol  = 0;
    logic ce_prev  = 1'b0;
    logic [TRIM_W-1:0] last_trim = TRIM_W'(32);

    typedef struct {
        logic [TRIM_W-1:0] trim;
        logic [N-1:0]      result;
        bit                err;
        bit                locked;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    fcounter_trim_sar dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .target         (target),
        .fcounter_rdy   (fcounter_rdy),
        .fcounter_eom   (fcounter_eom),
        .fcounter_adata (fcounter_adata),
        .fcounter_som   (fcounter_som),
        .fcounter_ce    (fcounter_ce),
        .trim           (trim),
        .result         (result),
        .busy           (busy),
        .done           (done),
        .error          (error)
`ifdef FCOUNTER_TRIM_FINAL_CHECK_EN
        ,
        .locked         (locked)
`endif
    );

    function automatic logic [N-1:0] cnt_of(input int t);
        int c;
        c = mult * t;
        if (c > 255) c = 255;
        return N'(c);
    endfunction

    assign fcounter_rdy   = !rdy_ovr && !m_run && !m_eom;
    assign fcounter_eom   = m_eom;
    assign fcounter_adata = m_adata;

    // fcounter model: som+ce starts, ce stops and raises eom, ce while eom acks.
    always @(posedge clk) begin
        if (rst || model_rst) begin
            m_run <= 1'b0;
            m_eom <= 1'b0;
        end else if (fcounter_ce) begin
            if (m_eom) begin
                m_eom <= 1'b0;
            end else if (fcounter_som) begin
                m_run <= !hang;
                m_eom <= hang;
            end else if (m_run) begin
                m_run   <= 1'b0;
                m_adata <= cnt_of(int'(trim));
                m_eom   <= 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (done) done_cnt <= done_cnt + 1;
        if (fcounter_ce) ce_cnt <= ce_cnt + 1;
        if (fcounter_ce && fcounter_som) arm_cnt <= arm_cnt + 1;
        if (fcounter_ce && ce_prev) ce_viol <= ce_viol + 1;
        ce_prev <= fcounter_ce;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_start(input logic [N-1:0] tgt);
        target = tgt;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask

    task automatic push_exp(input logic [N-1:0] tgt);
        exp_t e;
        int best = 0;
        for (int t = 0; t < (1 << TRIM_W); t++) begin
            if (cnt_of(t) <= tgt) best = t;
        end
        e.trim   = TRIM_W'(best);
`ifdef FCOUNTER_TRIM_FINAL_CHECK_EN
        e.result = cnt_of(best);
        e.locked = (e.result <= tgt) && (int'(tgt) - int'(e.result) <= TOL);
`else
        e.result = cnt_of(best | 1);
        e.locked = 1'b0;
`endif
        e.err    = 1'b0;
        sb.push_back(e);
    endtask

    task automatic wait_outcome(input string name);
        exp_t e;
        int n  = 0;
        int d0 = done_cnt;
        while (!done && !error && n < 6000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 6000) begin
            checks++; errors++;
            $display("FAIL %s completion: no done/error within 6000 cycles", name);
            if (sb.size() > 0) void'(sb.pop_front());
            return;
        end
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s scoreboard: outcome with no expected entry", name);
            return;
        end
        e = sb.pop_front();
        checks++;
        if (trim !== e.trim) begin
            errors++; $display("FAIL %s trim: got %0d want %0d", name, trim, e.trim);
        end
        checks++;
        if (error !== e.err) begin
            errors++; $display("FAIL %s error: got %0b want %0b", name, error, e.err);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL %s busy: got %0b want 0", name, busy);
        end
        if (!e.err) begin
            checks++;
            if (result !== e.result) begin
                errors++; $display("FAIL %s result: got %0d want %0d", name, result, e.result);
            end
`ifdef FCOUNTER_TRIM_FINAL_CHECK_EN
            checks++;
            if (locked !== e.locked) begin
                errors++; $display("FAIL %s locked: got %0b want %0b", name, locked, e.locked);
            end
`endif
        end else begin
            checks++;
            if (fcounter_som !== 1'b0) begin
                errors++; $display("FAIL %s som: got %0b want 0", name, fcounter_som);
            end
        end
        last_trim = e.trim;
        $display("txn %s: trim=%0d result=%0d error=%0b cycles=%0d", name, trim, result, error, n);
        tick(2);
        checks++;
        if ((done_cnt - d0) !== (e.err ? 0 : 1)) begin
            errors++; $display("FAIL %s done_pulses: got %0d want %0d", name, done_cnt - d0, e.err ? 0 : 1);
        end
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if ({trim, result, fcounter_som, fcounter_ce, busy, done, error} !== {TRIM_W'(32), N'(0), 5'b0}) begin
            errors++;
            $display("FAIL %s reset_values: trim=%0d result=%0d som=%0b ce=%0b busy=%0b done=%0b error=%0b want trim=32 rest 0",
                     name, trim, result, fcounter_som, fcounter_ce, busy, done, error);
        end
`ifdef FCOUNTER_TRIM_FINAL_CHECK_EN
        checks++;
        if (locked !== 1'b0) begin
            errors++; $display("FAIL %s reset_locked: got %0b want 0", name, locked);
        end
`endif
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        check_reset_values("reset");
        rst = 1'b0;
        tick(2);
    endtask

    task automatic test_search(input logic [N-1:0] tgt, input string name);
        push_exp(tgt);
        pulse_start(tgt);
        wait_outcome(name);
    endtask

    task automatic test_back_to_back();
        push_exp(8'd70);
        pulse_start(8'd70);
        tick(500);
        pulse_start(8'd5);
        tick(700);
        pulse_start(8'd200);
        wait_outcome("busy_start_ignored");
        push_exp(8'd10);
        pulse_start(8'd10);
        wait_outcome("back_to_back");
    endtask

    task automatic test_rdy_low();
        int c0 = ce_cnt;
        rdy_ovr = 1'b1;
        pulse_start(8'd70);
        tick(50);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL rdy_low busy: got %0b want 0", busy);
        end
        checks++;
        if (ce_cnt !== c0) begin
            errors++; $display("FAIL rdy_low ce_pulses: got %0d want 0", ce_cnt - c0);
        end
        checks++;
        if (trim !== last_trim) begin
            errors++; $display("FAIL rdy_low trim: got %0d want %0d", trim, last_trim);
        end
        rdy_ovr = 1'b0;
        tick(2);
    endtask

    task automatic test_timeout();
        exp_t e;
        e.trim = TRIM_W'(32); e.result = '0; e.err = 1'b1; e.locked = 1'b0;
        hang = 1'b1;
        sb.push_back(e);
        pulse_start(8'd70);
        wait_outcome("timeout");
        hang = 1'b0;
        model_rst = 1'b1;
        tick(1);
        model_rst = 1'b0;
        push_exp(8'd70);
        pulse_start(8'd70);
        checks++;
        if (error !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("FAIL restart_clears_error: error=%0b busy=%0b want error=0 busy=1", error, busy);
        end
        wait_outcome("after_timeout");
    endtask

    task automatic test_rst_mid();
        int a0 = arm_cnt;
        int n  = 0;
        int c0;
        pulse_start(8'd70);
        while ((arm_cnt - a0) < 3 && n < 8000) begin
            tick(1);
            n++;
        end
        checks++;
        if ((arm_cnt - a0) < 3) begin
            errors++; $display("FAIL rst_mid reach_step3: got %0d arms want 3", arm_cnt - a0);
        end
        tick(100);
        rst = 1'b1;
        tick(1);
        check_reset_values("rst_mid");
        rst = 1'b0;
        c0 = ce_cnt;
        tick(400);
        checks++;
        if (ce_cnt !== c0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_mid quiet: ce_pulses=%0d busy=%0b want 0 0", ce_cnt - c0, busy);
        end
        push_exp(8'd70);
        pulse_start(8'd70);
        wait_outcome("after_rst_mid");
    endtask

    task automatic test_ce_spacing();
        checks++;
        if (ce_viol !== 0) begin
            errors++; $display("FAIL ce_spacing: got %0d back-to-back ce want 0", ce_viol);
        end
    endtask

    initial begin
        test_reset();
        mult = 2;
        test_search(8'd70,  "target70");
        test_search(8'd0,   "target0");
        test_search(8'd255, "target255");
        test_search(N'($urandom_range(0, 255)), "target_random");
        test_back_to_back();
        test_rdy_low();
        test_timeout();
        test_rst_mid();
`ifdef FCOUNTER_TRIM_FINAL_CHECK_EN
        test_search(8'd71, "final_tol_lock");
        mult = 3;
        test_search(8'd70, "final_mult3");
        mult = 2;
`endif
        test_ce_spacing();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
